// File: rtl/tmec_decode_ibm_serial_pkg.sv
// Shared types and field helpers for the serial inversionless BM key-equation solver.
// Only primitive trinomials x^M + x^k + 1 are supported; a zero tap means "needs a pentanomial".
package tmec_decode_ibm_serial_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DISC = 2'd1,
        ST_UPD  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    function automatic int bch_trinomial_tap(input int m);
        case (m)
            2, 3, 4, 6, 7, 15: return 1;
            5, 11:             return 2;
            10:                return 3;
            9:                 return 4;
            default:           return 0;
        endcase
    endfunction

    function automatic bit bch_is_pentanomial(input int m);
        return bch_trinomial_tap(m) == 0;
    endfunction

endpackage

// File: rtl/tmec_ibm_gf_mul.sv
// Combinational standard-basis GF(2^M) multiplier over the primitive trinomial for M.
// Shift-and-add: a is multiplied by x once per bit of b, reducing as it goes.
module tmec_ibm_gf_mul
    import tmec_decode_ibm_serial_pkg::*;
#(
    parameter int M = 4
) (
    input  logic [M-1:0] a,
    input  logic [M-1:0] b,
    output logic [M-1:0] p
);

    localparam int TAP = bch_trinomial_tap(M);
    localparam logic [M-1:0] RED = M'(1) | (M'(1) << TAP);

    generate
        if (bch_is_pentanomial(M)) begin : g_bad_poly
            $error("tmec_ibm_gf_mul: no primitive trinomial exists for this M");
        end
    endgenerate

    always_comb begin
        logic [M-1:0] acc;
        acc = a;
        p   = '0;
        for (int j = 0; j < M; j++) begin
            if (b[j]) begin
                p = p ^ acc;
            end
            acc = {acc[M-2:0], 1'b0} ^ (acc[M-1] ? RED : '0);
        end
    end

endmodule

// File: rtl/tmec_decode_ibm_serial.sv
// Serial odd-step inversionless Berlekamp-Massey solver for binary BCH: 2T syndromes in,
// unnormalised error locator sigma(x) and its degree out, one coefficient slot per cycle.
module tmec_decode_ibm_serial
    import tmec_decode_ibm_serial_pkg::*;
#(
    parameter int M = 4,
    parameter int T = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [M*2*T-1:0]       syn,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [M*(T+1)-1:0]     sigma,
    output logic [$clog2(T+1)-1:0] err_count,
    output logic                   syn_zero
);

    localparam int CW = $clog2(T+1);
    localparam int KW = $clog2(T) + 2;

    state_e          state_q, state_d;
    logic [M-1:0]    syn_w [2*T];
    logic [M-1:0]    syn_q [2*T], syn_d [2*T];
    logic [M-1:0]    lam_q [T+1], lam_d [T+1];
    logic [M-1:0]    b_q [T+1], b_d [T+1];
    logic [M-1:0]    gamma_q, gamma_d, delta_q, delta_d;
    logic [M-1:0]    lam_prev_q, lam_prev_d, b_prev_q, b_prev_d, b_prev2_q, b_prev2_d;
    logic [KW-1:0]   k_q, k_d;
    logic [CW-1:0]   i_q, i_d, r_q, r_d, err_q, err_d, lam_deg;
    logic            zero_q, zero_d;
    logic [M-1:0]    syn_sel, p_disc, p_gl, p_db;
    logic            accept, last_slot, syn_all_zero, upd_b;

    genvar gi;
    generate
        for (gi = 0; gi < 2*T; gi++) begin : g_syn_unpack
            assign syn_w[gi] = syn[gi*M +: M];
        end
        for (gi = 0; gi <= T; gi++) begin : g_sigma_pack
            assign sigma[gi*M +: M] = lam_q[gi];
        end
    endgenerate

    assign accept       = in_valid & in_ready;
    assign last_slot    = (i_q == CW'(T));
    assign syn_all_zero = (syn == '0);
    assign upd_b        = (delta_q != '0) && !k_q[KW-1];

    // S_(2r+1-i), with indices below 1 reading as zero
    always_comb begin
        int sidx;
        sidx    = 2 * int'(r_q) + 1 - int'(i_q);
        syn_sel = '0;
        for (int j = 0; j < 2*T; j++) begin
            if (sidx == j + 1) begin
                syn_sel = syn_q[j];
            end
        end
    end

    tmec_ibm_gf_mul #(.M(M)) u_mul_disc (.a(lam_q[0]), .b(syn_sel),  .p(p_disc));
    tmec_ibm_gf_mul #(.M(M)) u_mul_gl   (.a(gamma_q),  .b(lam_q[0]), .p(p_gl));
    tmec_ibm_gf_mul #(.M(M)) u_mul_db   (.a(delta_q),  .b(b_prev_q), .p(p_db));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = syn_all_zero ? ST_DONE : ST_DISC;
            ST_DISC: if (last_slot) state_d = ST_UPD;
            ST_UPD:  if (last_slot) state_d = (r_q == CW'(T-1)) ? ST_DONE : ST_DISC;
            ST_DONE: if (out_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        syn_d      = syn_q;
        lam_d      = lam_q;
        b_d        = b_q;
        gamma_d    = gamma_q;
        delta_d    = delta_q;
        lam_prev_d = lam_prev_q;
        b_prev_d   = b_prev_q;
        b_prev2_d  = b_prev2_q;
        k_d        = k_q;
        i_d        = i_q;
        r_d        = r_q;
        err_d      = err_q;
        zero_d     = zero_q;
        lam_deg    = '0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    syn_d = syn_w;
                    for (int j = 0; j <= T; j++) begin
                        lam_d[j] = '0;
                        b_d[j]   = '0;
                    end
                    lam_d[0] = M'(1);
                    b_d[0]   = M'(1);
                    gamma_d  = M'(1);
                    delta_d  = '0;
                    k_d      = '0;
                    i_d      = '0;
                    r_d      = '0;
                    zero_d   = syn_all_zero;
                end
            end
            ST_DISC: begin
                delta_d = ((i_q == '0) ? '0 : delta_q) ^ p_disc;
                for (int j = 0; j < T; j++) lam_d[j] = lam_q[j+1];
                lam_d[T]   = lam_q[0];
                lam_prev_d = '0;
                b_prev_d   = '0;
                b_prev2_d  = '0;
                i_d        = last_slot ? '0 : i_q + CW'(1);
            end
            ST_UPD: begin
                // Both rotators advance one slot; the new coefficient re-enters at the tail.
                for (int j = 0; j < T; j++) begin
                    lam_d[j] = lam_q[j+1];
                    b_d[j]   = b_q[j+1];
                end
                lam_d[T]   = p_gl ^ p_db;
                b_d[T]     = upd_b ? lam_prev_q : b_prev2_q;
                lam_prev_d = lam_q[0];
                b_prev_d   = b_q[0];
                b_prev2_d  = b_prev_q;
                i_d        = last_slot ? '0 : i_q + CW'(1);
                if (last_slot) begin
                    r_d = r_q + CW'(1);
                    // The skipped even step always has zero discrepancy, so it is folded in here.
                    if (upd_b) begin
                        gamma_d = delta_q;
                        k_d     = KW'(0) - k_q;
                    end else begin
                        k_d     = k_q + KW'(1);
                    end
                end
            end
            default: ;
        endcase
        for (int j = 0; j <= T; j++) begin
            if (lam_d[j] != '0) lam_deg = CW'(j);
        end
        if (state_d == ST_DONE && state_q != ST_DONE) begin
            err_d = lam_deg;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int j = 0; j < 2*T; j++) syn_q[j] <= '0;
            for (int j = 0; j <= T; j++) begin
                lam_q[j] <= (j == 0) ? M'(1) : '0;
                b_q[j]   <= (j == 0) ? M'(1) : '0;
            end
            gamma_q    <= M'(1);
            delta_q    <= '0;
            lam_prev_q <= '0;
            b_prev_q   <= '0;
            b_prev2_q  <= '0;
            k_q        <= '0;
            i_q        <= '0;
            r_q        <= '0;
            err_q      <= '0;
            zero_q     <= 1'b0;
        end else begin
            syn_q      <= syn_d;
            lam_q      <= lam_d;
            b_q        <= b_d;
            gamma_q    <= gamma_d;
            delta_q    <= delta_d;
            lam_prev_q <= lam_prev_d;
            b_prev_q   <= b_prev_d;
            b_prev2_q  <= b_prev2_d;
            k_q        <= k_d;
            i_q        <= i_d;
            r_q        <= r_d;
            err_q      <= err_d;
            zero_q     <= zero_d;
        end
    end

    always_comb begin
        in_ready  = (state_q == ST_IDLE);
        out_valid = (state_q == ST_DONE);
        err_count = err_q;
        syn_zero  = zero_q;
    end

endmodule
